// File: rtl/pixel_prefetch.sv
// pixel_prefetch: pulls gray pixels from the RP2040 frame buffer over the
// strobe/rewind pin protocol, samples each response after a programmable
// latency and queues it in a show-ahead FIFO for the VGA timing stage.
// A frame start rewinds the frame buffer and flushes the queue; popping an
// empty queue raises a sticky underrun flag.
module pixel_prefetch #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [1:0]        sample_delay,
  input  logic              pixel_req,
  output logic [DATA_W-1:0] pixel_out,
  output logic              pixel_valid,
  output logic              underrun,
  output logic              frame_next_pixel_out,
  output logic              frame_reset_out,
  input  logic [DATA_W-1:0] frame_pixel_in
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_RST_FB = 2'd0,
    S_IDLE   = 2'd1,
    S_STROBE = 2'd2,
    S_WAIT   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              rst_cnt_q, rst_cnt_d;
  logic [1:0]        wait_cnt_q, wait_cnt_d;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              underrun_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              push_en;
  logic              pop_en;

  // FIFO handshake: a sample is pushed on the edge ending the last WAIT
  // cycle; a pop needs a non-empty queue. count_d is the occupancy after
  // this cycle's push/pop and also steers the WAIT exit decision.
  always_comb begin
    push_en = (state_q == S_WAIT) && (wait_cnt_q == 2'd0);
    pop_en  = pixel_req && (count_q != '0);
    count_d = count_q + CW'(push_en) - CW'(pop_en);
  end

  // State register for the fetch sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RST_FB;
      rst_cnt_q  <= 1'b1;
      wait_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic; frame_start overrides everything and restarts the rewind.
  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    wait_cnt_d = wait_cnt_q;
    if (frame_start) begin
      state_d   = S_RST_FB;
      rst_cnt_d = 1'b1;
    end else begin
      case (state_q)
        S_RST_FB: begin
          if (rst_cnt_q == 1'b0) state_d = S_IDLE;
          else                   rst_cnt_d = 1'b0;
        end
        S_IDLE: begin
          if (count_q < DEPTH_C) state_d = S_STROBE;
        end
        S_STROBE: begin
          // Latency is latched here so later sample_delay changes leave
          // the fetch in flight untouched.
          wait_cnt_d = sample_delay;
          state_d    = S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt_q != 2'd0) wait_cnt_d = wait_cnt_q - 2'd1;
          else                    state_d = (count_d < DEPTH_C) ? S_STROBE : S_IDLE;
        end
        default: state_d = S_RST_FB;
      endcase
    end
  end

  // Pin outputs decode the state register only, so they never glitch.
  always_comb begin
    frame_reset_out      = (state_q == S_RST_FB);
    frame_next_pixel_out = (state_q == S_STROBE);
  end

  // FIFO pointers, occupancy and sticky underrun; frame_start flushes all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      underrun_q <= 1'b0;
    end else if (frame_start) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (pixel_req && (count_q == '0)) underrun_q <= 1'b1;
    end
  end

  // Sample storage; an abandoned fetch never writes because frame_start wins.
  always_ff @(posedge clk) begin
    if (push_en && !frame_start) mem_q[wr_ptr_q] <= frame_pixel_in;
  end

  // Show-ahead head; forced to zero while the queue is empty.
  always_comb begin
    pixel_valid = (count_q != '0);
    pixel_out   = pixel_valid ? mem_q[rd_ptr_q] : '0;
    underrun    = underrun_q;
  end

endmodule

// File: tb/tb_pixel_prefetch.sv
// tb_pixel_prefetch: drives pixel_prefetch against an RP2040 pin model and a
// queue-based reference of the prefetch FIFO, with directed scenarios
// followed by randomized traffic, resets and rewinds.
module tb_pixel_prefetch;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 4;
  localparam int SRC_N  = 4096;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              frame_start = 1'b0;
  logic [1:0]        sample_delay = 2'd0;
  logic              pixel_req = 1'b0;
  logic [DATA_W-1:0] pixel_out;
  logic              pixel_valid;
  logic              underrun;
  logic              frame_next_pixel_out;
  logic              frame_reset_out;
  logic [DATA_W-1:0] frame_pixel_in = '0;

  always #5 clk = ~clk;

  pixel_prefetch #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .frame_start          (frame_start),
    .sample_delay         (sample_delay),
    .pixel_req            (pixel_req),
    .pixel_out            (pixel_out),
    .pixel_valid          (pixel_valid),
    .underrun             (underrun),
    .frame_next_pixel_out (frame_next_pixel_out),
    .frame_reset_out      (frame_reset_out),
    .frame_pixel_in       (frame_pixel_in)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs != expv) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Source frame held by the RP2040 model.
  int src [SRC_N];

  // RP2040 pin model state.
  int rp_idx;
  int rp_val;
  int rp_ready;
  bit rp_active;
  int rp_lat = -1;      // cycles after strobe until data valid; -1 => d+1

  // Reference model of the prefetch queue.
  int exp_q[$];
  bit exp_underrun;
  bit pend;
  int pend_due;
  int pend_val;
  int rstfb_left;
  int cyc;
  int gap;
  int strobe_t[$];
  int dut_pops[$];
  bit last_strobe;

  // Per-cycle checker and model advance, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      check_val("rst_frame_reset", int'(frame_reset_out), 1);
      check_val("rst_strobe", int'(frame_next_pixel_out), 0);
      check_val("rst_valid", int'(pixel_valid), 0);
      check_val("rst_pixel_out", int'(pixel_out), 0);
      check_val("rst_underrun", int'(underrun), 0);
      exp_q.delete();
      exp_underrun = 0;
      pend = 0;
      rstfb_left = 2;
      cyc = 0;
      gap = 0;
      rp_idx = 0;
      rp_active = 0;
      last_strobe = 0;
    end else begin
      check_val("pixel_valid", int'(pixel_valid), int'(exp_q.size() > 0));
      check_val("pixel_out", int'(pixel_out), (exp_q.size() > 0) ? exp_q[0] : 0);
      check_val("underrun", int'(underrun), int'(exp_underrun));
      check_val("frame_reset_out", int'(frame_reset_out), int'(rstfb_left > 0));
      if (rstfb_left > 0) check_val("strobe_in_rewind", int'(frame_next_pixel_out), 0);
      if (frame_next_pixel_out) begin
        check_val("strobe_while_busy", int'(pend), 0);
        check_val("strobe_when_full", int'(exp_q.size() < DEPTH), 1);
        strobe_t.push_back(cyc);
      end
      if (!frame_next_pixel_out && !pend && rstfb_left == 0 && exp_q.size() < DEPTH) gap++;
      else gap = 0;
      if (gap > 1) begin
        check_val("fetch_stall", gap, 1);
        gap = 0;
      end

      // RP2040 side: rewinds while frame_reset is high, serves each strobe.
      if (frame_reset_out) begin
        rp_idx = 0;
        rp_active = 0;
      end else if (frame_next_pixel_out) begin
        rp_val = src[rp_idx % SRC_N];
        rp_idx++;
        rp_active = 1;
        rp_ready = cyc + ((rp_lat >= 0) ? rp_lat : int'(sample_delay) + 1);
      end

      // Queue model for the edge that ends this cycle.
      if (frame_start) begin
        exp_q.delete();
        exp_underrun = 0;
        pend = 0;
        rstfb_left = 2;
      end else begin
        if (rstfb_left > 0) rstfb_left--;
        if (pixel_req) begin
          if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            dut_pops.push_back(int'(pixel_out));
            $display("pop %0d: pixel 0x%0h", dut_pops.size(), pixel_out);
          end else begin
            exp_underrun = 1;
          end
        end
        if (pend && cyc == pend_due) begin
          exp_q.push_back(pend_val);
          pend = 0;
        end
        if (frame_next_pixel_out) begin
          pend = 1;
          pend_due = cyc + int'(sample_delay) + 1;
          pend_val = rp_val;
        end
      end

      // Drive the pixel bus for the next cycle: data once ready, else noise.
      if (rp_active && (cyc + 1 >= rp_ready)) frame_pixel_in = DATA_W'(rp_val);
      else frame_pixel_in = DATA_W'(rp_val + 1 + int'($urandom_range(14, 0)));

      last_strobe = frame_next_pixel_out;
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_one(input string tag, input int expv);
    check_val(tag, int'(pixel_out), expv);
    pixel_req = 1'b1;
    tick();
    pixel_req = 1'b0;
  endtask

  // One-cycle frame_start, optionally loading a new source frame and delay.
  task automatic rewind(input bit new_src, input logic [1:0] d, input int lat);
    if (new_src) for (int i = 0; i < SRC_N; i++) src[i] = int'($urandom_range(15, 0));
    sample_delay = d;
    rp_lat = lat;
    pixel_req = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  int base;
  int pbase;
  int t;
  int n_rf;
  int exp2 [4];

  initial begin
    for (int i = 0; i < SRC_N; i++) src[i] = (i + 1) % 16;
    exp2[0] = 2; exp2[1] = 3; exp2[2] = 4; exp2[3] = 5;

    // Reset release, d = 0: rewind for 2 cycles, strobes every 2 cycles.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) tick();
    check_val("t1_strobe_count", strobe_t.size(), 4);
    for (int i = 0; i < strobe_t.size() && i < 4; i++)
      check_val("t1_strobe_cycle", strobe_t[i], 3 + 2 * i);
    check_val("t1_valid", int'(pixel_valid), 1);
    check_val("t1_head", int'(pixel_out), 1);

    // Full FIFO, one pop: exactly one refill strobe, 5 lands in the tail.
    base = strobe_t.size();
    pop_one("t2_pop_head", 1);
    check_val("t2_new_head", int'(pixel_out), 2);
    repeat (10) tick();
    check_val("t2_refill_strobes", strobe_t.size() - base, 1);
    for (int i = 0; i < 4; i++) pop_one("t2_order", exp2[i]);

    // d = 3 with data arriving 4 cycles after each strobe: period 5.
    rewind(1'b1, 2'd3, 4);
    base  = strobe_t.size();
    pbase = dut_pops.size();
    for (int i = 0; i < 60; i++) begin
      pixel_req = pixel_valid;
      tick();
    end
    pixel_req = 1'b0;
    check_val("t3_strobes_seen", int'(strobe_t.size() - base >= 9), 1);
    for (int i = base + 1; i < strobe_t.size() && i < base + 9; i++)
      check_val("t3_period", strobe_t[i] - strobe_t[i-1], 5);
    check_val("t3_pops_seen", int'(dut_pops.size() - pbase >= 8), 1);
    for (int i = 0; i < 8 && pbase + i < dut_pops.size(); i++)
      check_val("t3_stream", dut_pops[pbase + i], src[i]);

    // Underrun on an empty FIFO: sticky until the next frame_start.
    rewind(1'b1, 2'd0, -1);
    pixel_req = 1'b1;
    tick();
    pixel_req = 1'b0;
    check_val("t4_underrun_set", int'(underrun), 1);
    check_val("t4_still_empty", int'(pixel_valid), 0);
    repeat (8) tick();
    check_val("t4_underrun_sticky", int'(underrun), 1);
    check_val("t4_first_pixel", int'(pixel_out), src[0]);
    rewind(1'b0, 2'd0, -1);
    check_val("t4_underrun_clear", int'(underrun), 0);

    // frame_start during WAIT with 2 entries queued: flush, rewind, restart.
    rewind(1'b1, 2'd3, -1);
    base = strobe_t.size();
    t = 0;
    while (strobe_t.size() < base + 3 && t < 100) begin
      tick();
      t++;
    end
    check_val("t5_strobe_timeout", int'(t < 100), 1);
    tick();
    check_val("t5_two_queued", int'(pixel_valid), 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check_val("t5_flushed", int'(pixel_valid), 0);
    n_rf = 0;
    for (int i = 0; i < 6; i++) begin
      n_rf += int'(frame_reset_out);
      tick();
    end
    check_val("t5_rewind_cycles", n_rf, 2);
    t = 0;
    while (!pixel_valid && t < 50) begin
      tick();
      t++;
    end
    check_val("t5_refill_timeout", int'(t < 50), 1);
    check_val("t5_first_pixel", int'(pixel_out), src[0]);

    // Steady streaming: d = 1, a pop every 4th cycle for 10000 cycles.
    rewind(1'b1, 2'd1, -1);
    repeat (20) tick();
    pbase = dut_pops.size();
    for (int i = 0; i < 10000; i++) begin
      pixel_req = (i % 4 == 0);
      tick();
    end
    pixel_req = 1'b0;
    check_val("t6_no_underrun", int'(underrun), 0);
    check_val("t6_pop_count", dut_pops.size() - pbase, 2500);
    for (int i = 0; pbase + i < dut_pops.size(); i++)
      check_val("t6_stream", dut_pops[pbase + i], src[i]);

    // Randomized traffic: random pops, delay changes mid-fetch, rewinds
    // and one asynchronous reset released in the middle of a fetch.
    rewind(1'b1, 2'd2, -1);
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        t = 0;
        while (!last_strobe && t < 20) begin
          tick();
          t++;
        end
        pixel_req = 1'b0;
        frame_start = 1'b0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
      end
      pixel_req   = ($urandom_range(2, 0) == 0);
      frame_start = ($urandom_range(199, 0) == 0);
      if (last_strobe && $urandom_range(1, 0) == 1) sample_delay = 2'($urandom_range(3, 0));
      tick();
    end
    pixel_req = 1'b0;
    frame_start = 1'b0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
